// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared state encodings for the auto-reset counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_autoreset_param_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear (clear wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != c_MAX)) begin
            count_d = count_q + c_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/counter_autoreset_param.sv
`default_nettype none
// ============================================================================
//  Module      : counter_autoreset_param
//  Description : Up/down counter with periodic or one-shot autoreset pulse.
//                Define COUNTER_AUTORESET_WRAP_COUNT_EN to add wrap_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_autoreset_param
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  limit,
    input  logic              dir,
    input  logic              oneshot,
    output logic [WIDTH-1:0]  value,
    output logic              autoreset,
    output logic              busy,
    output logic              done
`ifdef COUNTER_AUTORESET_WRAP_COUNT_EN
    ,
    output logic [WRAP_W-1:0] wrap_count
`endif
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] value_q,     value_d;
    logic [WIDTH-1:0] limit_q,     limit_d;
    logic             dir_q,       dir_d;
    logic             oneshot_q,   oneshot_d;
    logic             autoreset_q, autoreset_d;

    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] reload;

    assign term   = dir_q ? '0 : limit_q;
    assign reload = dir_q ? limit_q : '0;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        limit_d     = limit_q;
        dir_d       = dir_q;
        oneshot_d   = oneshot_q;
        autoreset_d = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            value_d = '0;
        end else if (start) begin
            // Restart from any state discards the running count.
            limit_d   = limit;
            dir_d     = dir;
            oneshot_d = oneshot;
            value_d   = dir ? limit : '0;
            state_d   = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    value_d = '0;
                end
                ST_RUN: begin
                    if (en) begin
                        if (value_q == term) begin
                            value_d     = reload;
                            autoreset_d = 1'b1;
                            if (oneshot_q) begin
                                state_d = ST_HOLD;
                            end
                        end else if (dir_q) begin
                            value_d = value_q - c_ONE;
                        end else begin
                            value_d = value_q + c_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    value_d = value_q;
                end
                default: begin
                    // Illegal encoding falls back to a clean idle.
                    state_d = ST_IDLE;
                    value_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            value_q     <= '0;
            limit_q     <= '0;
            dir_q       <= 1'b0;
            oneshot_q   <= 1'b0;
            autoreset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            limit_q     <= limit_d;
            dir_q       <= dir_d;
            oneshot_q   <= oneshot_d;
            autoreset_q <= autoreset_d;
        end
    end

    assign value     = value_q;
    assign autoreset = autoreset_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_HOLD);

`ifdef COUNTER_AUTORESET_WRAP_COUNT_EN
    sat_counter #(
        .WIDTH (WRAP_W)
    ) u_wrap_count (
        .clk   (clk),
        .rst   (rst),
        .clr   (start | stop),
        .inc   (autoreset_d),
        .count (wrap_count)
    );
`else
    logic unused_wrap_w;
    assign unused_wrap_w = ^WRAP_W;
`endif

endmodule : counter_autoreset_param
`default_nettype wire

// File: tb/tb_counter_autoreset_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_autoreset_param
//  Description : Scoreboard bench for counter_autoreset_param.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_autoreset_param;

    localparam int c_WIDTH  = 8;
    localparam int c_WRAP_W = 2;

    logic               clk;
    logic               rst;
    logic               en;
    logic               start;
    logic               stop;
    logic [c_WIDTH-1:0] limit;
    logic               dir;
    logic               oneshot;
    logic [c_WIDTH-1:0] value;
    logic               autoreset;
    logic               busy;
    logic               done;
`ifdef COUNTER_AUTORESET_WRAP_COUNT_EN
    logic [c_WRAP_W-1:0] wrap_count;
`endif

    typedef struct {
        string              tag;
        logic [c_WIDTH-1:0] v;
        logic               ar;
        logic               bz;
        logic               dn;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    counter_autoreset_param #(
        .WIDTH  (c_WIDTH),
        .WRAP_W (c_WRAP_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .stop      (stop),
        .limit     (limit),
        .dir       (dir),
        .oneshot   (oneshot),
        .value     (value),
        .autoreset (autoreset),
        .busy      (busy),
        .done      (done)
`ifdef COUNTER_AUTORESET_WRAP_COUNT_EN
        ,
        .wrap_count(wrap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs not under test carry junk to prove they are ignored.
    task automatic step(input string tag, input logic i_en, input logic i_start, input logic i_stop,
                        input logic [c_WIDTH-1:0] i_limit, input logic i_dir, input logic i_os,
                        input logic [c_WIDTH-1:0] e_v, input logic e_ar, input logic e_bz,
                        input logic e_dn);
        exp_t e;
        en      = i_en;
        start   = i_start;
        stop    = i_stop;
        limit   = i_start ? i_limit : 8'hF0;
        dir     = i_start ? i_dir   : ~i_dir;
        oneshot = i_start ? i_os    : 1'b1;
        e.tag = tag; e.v = e_v; e.ar = e_ar; e.bz = e_bz; e.dn = e_dn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".value"},     32'(value),     32'(e.v));
        chk({e.tag, ".autoreset"}, 32'(autoreset), 32'(e.ar));
        chk({e.tag, ".busy"},      32'(busy),      32'(e.bz));
        chk({e.tag, ".done"},      32'(done),      32'(e.dn));
    endtask

    task automatic run(input string tag, input logic i_en, input logic [c_WIDTH-1:0] e_v,
                       input logic e_ar, input logic e_bz, input logic e_dn);
        step(tag, i_en, 1'b0, 1'b0, '0, 1'b0, 1'b0, e_v, e_ar, e_bz, e_dn);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
        limit = '0; dir = 1'b0; oneshot = 1'b0;
        #2;
        chk("reset.value",     32'(value),     32'd0);
        chk("reset.autoreset", 32'(autoreset), 32'd0);
        chk("reset.busy",      32'(busy),      32'd0);
        chk("reset.done",      32'(done),      32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        run("idle_en", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

        // Periodic up, limit 3: period of four enabled cycles.
        step("up_start", 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        begin
            logic [c_WIDTH-1:0] seq [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
            for (int i = 0; i < 8; i++)
                run($sformatf("up%0d", i), 1'b1, seq[i], (seq[i] == 8'd0), 1'b1, 1'b0);
        end
        run("up_hold", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step("up_stop", 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // One-shot down, limit 2.
        step("os_start", 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
        run("os1",   1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        run("os0",   1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        run("os_tm", 1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
        run("os_h1", 1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
        run("os_h2", 1'b1, 8'd2, 1'b0, 1'b0, 1'b1);

        // Limit 0: every enabled cycle is terminal.
        step("z_start", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        run("z_en1", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        run("z_en0", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        run("z_en1b", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
        run("z_en1c", 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);

        // Priority and restart.
        step("p_start", 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        run("p1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        step("p_both", 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step("r_start", 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        run("r1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b0);
        run("r2", 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
        step("r_restart", 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++)
            run($sformatf("r6_%0d", i), 1'b1, 8'(i % 6), (i == 6), 1'b1, 1'b0);

        // Asynchronous reset mid-run at value 5.
        step("a_start", 1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++)
            run($sformatf("a%0d", i), 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async.value",     32'(value),     32'd0);
        chk("async.autoreset", 32'(autoreset), 32'd0);
        chk("async.busy",      32'(busy),      32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run("post_rst", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);

`ifdef COUNTER_AUTORESET_WRAP_COUNT_EN
        step("w_start", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("wrap.cleared", 32'(wrap_count), 32'd0);
        begin
            logic [c_WRAP_W-1:0] wexp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                run($sformatf("w%0d", i), 1'b1, 8'd0, 1'b1, 1'b1, 1'b0);
                chk($sformatf("wrap%0d", i), 32'(wrap_count), 32'(wexp[i]));
            end
        end
        step("w_restart", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("wrap.restart", 32'(wrap_count), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_counter_autoreset_param
`default_nettype wire

// File: doc/counter_autoreset_param.md
Name: counter_autoreset_param

Overview:
- Parametrised successor of the lab auto-reset counter.
- Counts enabled cycles up or down between 0 and a limit, and emits a one-cycle autoreset pulse at each terminal event.
- Supports periodic (free-running) and one-shot modes through a small IDLE/RUN/HOLD FSM.
- Used as a reusable timebase / event divider in later lab designs.

Parameters:
- WIDTH, 8: counter and limit width in bits.
- WRAP_W, 8: wrap-event counter width; used only with the optional feature.

Ports:
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous reset, active-high.
- en  in  1: count enable; when 0 the counter holds.
- start  in  1: start/restart pulse; samples limit, dir and oneshot.
- stop  in  1: abort to IDLE.
- limit  in  WIDTH: terminal value, sampled at start.
- dir  in  1: 0 = up (0 to limit_q), 1 = down (limit_q to 0); sampled at start.
- oneshot  in  1: 1 = stop after the first terminal event; sampled at start.
- value  out  WIDTH: current count, registered.
- autoreset  out  1: one-cycle pulse, registered, asserted on each terminal event.
- busy  out  1: high while in RUN.
- done  out  1: high while in HOLD (one-shot finished).

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. On rst=1: state=IDLE, value=0, limit_q=0, dir_q=0, oneshot_q=0, autoreset=0, busy=0, done=0.
- Internal registers: limit_q, dir_q, oneshot_q. Terminal value term = dir_q ? 0 : limit_q. Reload value rl = dir_q ? limit_q : 0.
- Input priority in every state: stop > start > normal operation.
- stop=1: next state IDLE, value=0, autoreset=0. Applies in any state.
- start=1 without stop:
  - limit_q<=limit, dir_q<=dir, oneshot_q<=oneshot.
  - value <= (dir ? limit : 0).
  - next state RUN.
  - Restart from RUN or HOLD behaves identically; the count is discarded.
- IDLE: value holds 0; autoreset=0; en is ignored.
- RUN with en=0: value holds; autoreset=0.
- RUN with en=1 and value!=term: value steps by +1 (up) or -1 (down); autoreset=0.
- RUN with en=1 and value==term (terminal event):
  - value<=rl and autoreset<=1 for exactly that next cycle.
  - If oneshot_q=1, next state is HOLD; otherwise stay in RUN.
- Period in periodic mode is limit_q+1 enabled cycles per autoreset pulse.
- limit_q=0: every enabled cycle in RUN is a terminal event; value stays 0 and autoreset stays high while en=1.
- HOLD: value holds rl; autoreset=0; en is ignored; leave only via start, stop or rst.
- Changes on limit, dir or oneshot outside a start cycle have no effect.
- No overflow is possible: value never leaves the range [0, limit_q].
- Arithmetic is unsigned, WIDTH bits. The comparison is equality only.
- busy = (state==RUN). done = (state==HOLD). Both are registered state decodes, with no combinational path from inputs.
- Latency: start at edge N gives value=reload at edge N+1. The first step happens at the first edge after that with en=1.

Optional Feature:
- Macro: COUNTER_AUTORESET_WRAP_COUNT_EN.
- Defined:
  - Adds output wrap_count [WRAP_W-1:0], reset to 0.
  - Increments on each autoreset pulse and saturates at all-ones.
  - Cleared to 0 on start or stop.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package/header counter_pkg holds the state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2.
- Unused encoding 2'd3 recovers to IDLE on the next clock.
- One natural sub-module: sat_counter (WRAP_W-bit saturating counter with clear). It is instantiated only under the macro.

Test Plan:
- Reset: assert rst mid-RUN with value=5 -> value=0, autoreset=0, busy=0 immediately, without waiting for a clock edge.
- Periodic up: limit=3, dir=0, oneshot=0, start, en=1 continuous -> value 0,1,2,3,0,1..., with an autoreset pulse coincident with each return to 0 (every 4 cycles).
- One-shot down: limit=2, dir=1, oneshot=1, start, en=1 -> value 2,1,0,2, then autoreset once, then done=1 with value held at 2 while en stays high.
- Enable gating and limit=0: limit=0 periodic, en toggles 1,0,1 -> autoreset 1,0,1 and value stays 0.
- Priority: start and stop together in RUN -> IDLE, value=0. Restart at value=2 with limit changed to 5 -> value=0 and new period 6.
- With COUNTER_AUTORESET_WRAP_COUNT_EN and WRAP_W=2: 5 wraps -> wrap_count 1,2,3,3,3. A following start -> wrap_count=0.
